// File: rtl/rr_arb_16_pkg.sv
// Shared constants for the 16-way round-robin arbiter and its bench.
package rr_arb_16_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // First set bit of req, searching circularly upward from ptr.
  // Returns ptr when req is empty (caller only uses it when |req).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder with enable; output all-zero when disabled.
module decoder_4_16 (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] onehot_o
);

  for (genvar i = 0; i < 16; i++) begin : g_dec
    assign onehot_o[i] = en_i && (sel_i == 4'(i));
  end

endmodule

// File: rtl/rr_arb_16.sv
// 16-requester round-robin arbiter with a per-grant hold limit and a
// one-cycle turnaround between grants.
module rr_arb_16
  import rr_arb_16_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               expired
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [HOLD_W-1:0] hold_q;
  logic              vld_q;
  logic              exp_q;

  // Candidate winner for the next IDLE arbitration.
  always_comb begin
    idx_d = rr_pick(req, ptr_q);
  end

  // Arbitration FSM; all outputs come straight from registers. The hold
  // counter saturates at MAX_HOLD-1 because reaching it forces release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      exp_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            idx_q   <= idx_d;
            vld_q   <= 1'b1;
            hold_q  <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[idx_q] || (hold_q == HOLD_LAST)) begin
            // A simultaneous drop and limit hit counts as a normal release.
            exp_q   <= req[idx_q];
            vld_q   <= 1'b0;
            ptr_q   <= idx_q + IDX_W'(1);
            state_q <= ST_RELEASE;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign expired   = exp_q;

  decoder_4_16 u_dec (
    .en_i     (vld_q),
    .sel_i    (idx_q),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_arb_16.sv
// Bench for rr_arb_16: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arb_16;
  import rr_arb_16_pkg::*;

  localparam int MAXH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               expired;

  int checks = 0;
  int errors = 0;

  rr_arb_16 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: who owns the resource, for how many cycles so far,
  // where the next search starts, and whether we are in the turnaround gap.
  int m_owner = -1;
  int m_age   = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_turn  = 1'b0;
  bit m_exp   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_age   <= 0;
      m_ptr   <= 0;
      m_last  <= 0;
      m_turn  <= 1'b0;
      m_exp   <= 1'b0;
    end else begin
      m_exp <= 1'b0;
      if (m_turn) begin
        m_turn <= 1'b0;
      end else if (m_owner < 0) begin
        if (req != 0) begin
          int w;
          w = -1;
          for (int k = 0; k < NUM_REQ; k++)
            if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
          m_owner <= w;
          m_last  <= w;
          m_age   <= 1;
        end
      end else if (!req[m_owner] || m_age == MAXH) begin
        m_exp   <= req[m_owner];
        m_ptr   <= (m_owner + 1) % NUM_REQ;
        m_owner <= -1;
        m_turn  <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] eg;
    eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_idx", 32'(gnt_idx), m_last);
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("expired", 32'(expired), 32'(m_exp));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int gap;
    int budget;
    logic [15:0] r;

    // Reset state
    rst_n = 1'b0;
    req   = '0;
    tick(); tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_expired", 32'(expired), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request, one-cycle latency, then release and idle
    req = 16'h0008; tick();
    check("single_gnt", 32'(gnt), 32'h0008);
    check("single_idx", 32'(gnt_idx), 32'd3);
    check("single_valid", 32'(gnt_valid), 32'd1);
    check("model_single_idx", m_last, 32'd3);
    req = 16'h0000; tick();
    check("single_rel_gnt", 32'(gnt), 32'h0);
    check("single_rel_valid", 32'(gnt_valid), 32'h0);
    check("single_rel_idx", 32'(gnt_idx), 32'd3);
    tick();
    check("single_idle_gnt", 32'(gnt), 32'h0);

    // Wrap search from ptr=14
    req = 16'h2000; tick();
    check("wrap_pre_idx", 32'(gnt_idx), 32'd13);
    req = 16'h0000; tick(); tick();
    req = 16'h0005; tick();
    check("wrap_idx0", 32'(gnt_idx), 32'd0);
    check("model_wrap_idx0", m_last, 32'd0);
    req = 16'h0004; tick(); tick(); tick();
    check("wrap_idx2", 32'(gnt_idx), 32'd2);
    check("wrap_gnt2", 32'(gnt), 32'h0004);

    // Hold limit: MAX_HOLD=4 cycles, then forced release with expired
    req = 16'h0000; tick(); tick();
    req = 16'h0100;
    for (int h = 0; h < MAXH; h++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'h0100);
    end
    tick();
    check("hold_rel_gnt", 32'(gnt), 32'h0);
    check("hold_expired", 32'(expired), 32'd1);
    check("model_expired", 32'(m_exp), 32'd1);
    tick();
    check("hold_idle_expired", 32'(expired), 32'd0);
    check("hold_idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("hold_regrant", 32'(gnt), 32'h0100);

    // Reset mid-grant drops gnt asynchronously
    req = 16'h0020; tick(); tick(); tick();
    check("pre_rst_gnt", 32'(gnt), 32'h0020);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_valid", 32'(gnt_valid), 32'h0);
    tick();
    req = 16'h0021; rst_n = 1'b1; tick();
    check("post_rst_idx", 32'(gnt_idx), 32'd0);
    check("post_rst_gnt", 32'(gnt), 32'h0001);

    // Interference: other bits toggle while 5 holds the grant
    req = 16'h0020; tick(); tick(); tick();
    check("intf_start", 32'(gnt), 32'h0020);
    for (int i = 0; i < 2; i++) begin
      r = 16'($urandom());
      req = (r & 16'hFFDF) | 16'h0020; tick();
      check("intf_hold", 32'(gnt), 32'h0020);
    end
    r = 16'($urandom());
    req = r & 16'hFFDF; tick();
    check("intf_drop_gnt", 32'(gnt), 32'h0);
    check("intf_drop_expired", 32'(expired), 32'h0);

    // Rotation with all requesters active, from a fresh reset
    req = 16'h0000;
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 16'hFFFF;
    gap = 0;
    for (int k = 0; k <= NUM_REQ; k++) begin
      budget = 0;
      tick();
      while (!gnt_valid && budget < 8) begin
        gap++; budget++;
        tick();
      end
      check("rot_timeout", 32'(gnt_valid), 32'd1);
      check("rot_idx", 32'(gnt_idx), 32'(k % NUM_REQ));
      if (k > 0) check("rot_gap", gap, 32'd2);
      tick();
      check("rot_second_cycle", 32'(gnt_valid), 32'd1);
      req[k % NUM_REQ] = 1'b0;
      tick();
      gap = 1;
      req = 16'hFFFF;
    end

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = 16'($urandom());
        2: req = 16'd1 << $urandom_range(0, 15);
        default: req = req ^ (16'd1 << $urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
      end
      tick();
    end

    req = '0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
